// File: rtl/iir_pkg.sv
// Shared constants for the IIR synthesis filter and its analysis-side FIR inverse:
// coefficient format, the a_k table, FSM state type and the output rounding/saturation.
package iir_pkg;

    localparam int ORDER     = 16;
    localparam int WIN       = 18;
    localparam int COEF_W    = 10;
    localparam int COEF_FRAC = 7;
    localparam int WOUT      = 18;
    localparam int ACC_W     = WIN + COEF_W + 5;
    localparam int IDX_W     = $clog2(ORDER + 1);

    localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1 << COEF_FRAC);

    // a_1..a_ORDER in Q3.7; the synthesis filter reads this same table.
    localparam logic signed [COEF_W-1:0] A_COEF [1:ORDER] = '{
        10'sd128, -10'sd141, 10'sd332, -10'sd298,
        10'sd485, -10'sd361, 10'sd426, -10'sd262,
        10'sd250, -10'sd124, 10'sd96,  -10'sd37,
        10'sd24,  -10'sd6,   10'sd3,   10'sd0
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_e;

    localparam logic signed [ACC_W:0] ROUND_BIAS = (ACC_W+1)'(1 << (COEF_FRAC - 1));
    localparam logic signed [ACC_W:0] SAT_HI     = (ACC_W+1)'((1 << (WOUT - 1)) - 1);
    localparam logic signed [ACC_W:0] SAT_LO     = ~SAT_HI;

    // c[0] is the implicit 1.0 of A(z); indices past ORDER read as zero.
    function automatic logic signed [COEF_W-1:0] coef_at(input logic [IDX_W-1:0] idx);
        if (idx == '0) begin
            return COEF_ONE;
        end
        if (int'(idx) > ORDER) begin
            return '0;
        end
        return A_COEF[idx];
    endfunction

    // One guard bit keeps the +0.5 bias from wrapping before the arithmetic shift.
    function automatic logic signed [WOUT-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W:0] wide;
        wide = ($signed({acc[ACC_W-1], acc}) + ROUND_BIAS) >>> COEF_FRAC;
        if (wide > SAT_HI) begin
            return SAT_HI[WOUT-1:0];
        end
        if (wide < SAT_LO) begin
            return SAT_LO[WOUT-1:0];
        end
        return wide[WOUT-1:0];
    endfunction

endpackage

// File: rtl/iir_mac_unit.sv
// Single signed multiply-accumulate slice: clear wins over enable, accumulator registered.
module iir_mac_unit
    import iir_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     en,
    input  logic signed [COEF_W-1:0] coef,
    input  logic signed [WIN-1:0]    sample,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [WIN+COEF_W-1:0] prod;
    logic signed [ACC_W-1:0]      acc_d;
    logic signed [ACC_W-1:0]      acc_q;

    assign prod = coef * sample;

    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/iir_analysis_fir.sv
// Analysis FIR e[n] = x[n] + sum a_k x[n-k], time-multiplexed over one MAC.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module iir_analysis_fir
    import iir_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [WIN-1:0]  in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [WOUT-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [1:0]      dbg_state
);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [WIN-1:0]   dly_q [0:ORDER];
    logic signed [WIN-1:0]   dly_d [0:ORDER];
    logic [WOUT-1:0]         out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;

    logic                    mac_clear;
    logic                    mac_en;
    logic signed [COEF_W-1:0] mac_coef;
    logic signed [WIN-1:0]   mac_sample;
    logic signed [ACC_W-1:0] acc;

    assign mac_coef   = coef_at(idx_q);
    assign mac_sample = dly_q[idx_q];

    iir_mac_unit u_mac (
        .clk    (clk),
        .rst    (rst),
        .clear  (mac_clear),
        .en     (mac_en),
        .coef   (mac_coef),
        .sample (mac_sample),
        .acc    (acc)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dly_d       = dly_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        mac_clear   = 1'b0;
        mac_en      = 1'b0;

        if (flush) begin
            for (int k = 0; k <= ORDER; k++) begin
                dly_d[k] = '0;
            end
            mac_clear   = 1'b1;
            out_valid_d = 1'b0;
            idx_d       = '0;
            state_d     = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        for (int k = ORDER; k > 0; k--) begin
                            dly_d[k] = dly_q[k-1];
                        end
                        dly_d[0]  = $signed(in_data);
                        mac_clear = 1'b1;
                        idx_d     = '0;
                        state_d   = MAC;
                    end
                end
                MAC: begin
                    mac_en = 1'b1;
                    if (idx_q == IDX_W'(ORDER)) begin
                        idx_d   = '0;
                        state_d = OUT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                OUT: begin
                    // First OUT cycle registers the result; valid then holds until taken.
                    if (!out_valid_q) begin
                        out_data_d  = round_sat(acc);
                        out_valid_d = 1'b1;
                    end else if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int k = 0; k <= ORDER; k++) begin
                dly_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            for (int k = 0; k <= ORDER; k++) begin
                dly_q[k] <= dly_d[k];
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_iir_analysis_fir.sv
// Bench for iir_analysis_fir: latency/handshake model plus FIR arithmetic model,
// per-cycle compare, scoreboard on output handshakes, literal impulse tables.
module tb_iir_analysis_fir;

  localparam int ORDER = 16;
  localparam int WIN   = 18;
  localparam int WOUT  = 18;
  localparam longint OMAX = 131071;
  localparam longint OMIN = -131072;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            flush = 1'b0;
  logic [WIN-1:0]  in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [WOUT-1:0] out_data;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [1:0]      dbg_state;

  always #5 clk = ~clk;

  iir_analysis_fir dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dbg_state (dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int c_tab [0:ORDER] = '{128, 128, -141, 332, -298, 485, -361, 426, -262,
                          250, -124, 96, -37, 24, -6, 3, 0};

  int imp1_q[$]  = '{1, 1, -1, 3, -2, 4, -3, 3, -2, 2, -1, 1, 0, 0, 0, 0, 0, 0};
  int impmax_q[$] = '{131071, 131071, -131072, 131071};
  int bp_q[$]    = '{1000, 3000};
  int aflush_q[$] = '{128, 128, -141};

  // model state
  longint hist [0:ORDER];
  bit     m_busy = 1'b0;
  int     m_cnt = 0;
  bit     m_valid = 1'b0;
  longint m_data = 0;
  longint m_pending = 0;
  logic [WOUT-1:0] exp_q[$];
  int     out_log[$];

  longint ramp_y [0:63];
  bit     ramp_clamped [0:63];

  task automatic check(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic longint sat_out(input longint v);
    if (v > OMAX) return OMAX;
    if (v < OMIN) return OMIN;
    return v;
  endfunction

  function automatic longint fir_residual();
    longint acc;
    acc = 0;
    for (int k = 0; k <= ORDER; k++) acc += longint'(c_tab[k]) * hist[k];
    return sat_out((acc + 64) >>> 7);
  endfunction

  // Model: one sample in flight, result valid ORDER+2 edges after accept.
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst || flush) begin
      for (int k = 0; k <= ORDER; k++) hist[k] = 0;
      m_busy  = 1'b0;
      m_cnt   = 0;
      m_valid = 1'b0;
      exp_q.delete();
    end else if (!m_busy) begin
      if (in_valid) begin
        for (int k = ORDER; k > 0; k--) hist[k] = hist[k-1];
        hist[0]   = longint'($signed(in_data));
        m_pending = fir_residual();
        m_busy    = 1'b1;
        m_cnt     = 0;
      end
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid = 1'b0;
        m_busy  = 1'b0;
      end
    end else begin
      m_cnt++;
      if (m_cnt == ORDER + 2) begin
        m_valid = 1'b1;
        m_data  = m_pending;
        exp_q.push_back(m_pending[WOUT-1:0]);
      end
    end
  end

  // Per-cycle compare and handshake scoreboard
  initial forever begin
    logic [WOUT-1:0] e;
    @(negedge clk);
    if (rst) begin
      check("in_ready", longint'(in_ready), longint'(!m_busy));
      check("out_valid", longint'(out_valid), longint'(m_valid));
      if (m_valid) check("out_data", longint'($signed(out_data)), m_data);
      if (out_valid && out_ready && !flush) begin
        out_log.push_back(int'($signed(out_data)));
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got %0d expected no output", $signed(out_data));
        end else begin
          e = exp_q.pop_front();
          check("sb_data", longint'($signed(out_data)), longint'($signed(e)));
        end
      end
    end
  end

  task automatic send(input longint v);
    bit got;
    got = 1'b0;
    in_data  = v[WIN-1:0];
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
    end
  endtask

  task automatic wait_log(input int n);
    for (int i = 0; i < 3000 && out_log.size() < n; i++) @(posedge clk);
    #1;
    if (out_log.size() < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL out_timeout: got %0d outputs expected %0d", out_log.size(), n);
    end
  endtask

  task automatic check_seq(input string name, input int base, input int exp[$]);
    for (int i = 0; i < exp.size(); i++) begin
      if (base + i < out_log.size()) begin
        check($sformatf("%s[%0d]", name, i), longint'(out_log[base+i]), longint'(exp[i]));
      end else begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s[%0d]: got none expected %0d", name, i, exp[i]);
      end
    end
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, longint'(in_ready), 1);
    check({tag, "_out_valid"}, longint'(out_valid), 0);
    check({tag, "_out_data"}, longint'($signed(out_data)), 0);
    check({tag, "_state"}, longint'(dbg_state), 0);
  endtask

  initial begin
    #400000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: got no finish expected finish before 400000");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int base;
    bit stall_ok;
    longint s, d;

    // reset state
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // unit impulse
    base = out_log.size();
    send(1);
    repeat (17) send(0);
    wait_log(base + 18);
    check_seq("impulse1", base, imp1_q);

    // full-scale impulse: saturation on both sides
    base = out_log.size();
    send(131071);
    repeat (3) send(0);
    wait_log(base + 4);
    check_seq("impulse_max", base, impmax_q);

    // loopback through a synthesis-filter model on a ramp
    repeat (2) @(posedge clk);
    #1;
    flush_pulse();
    for (int n = 0; n < 64; n++) begin
      s = 128 * (16 * longint'(n));
      for (int k = 1; k <= ORDER; k++) begin
        if (n - k >= 0) s -= longint'(c_tab[k]) * ramp_y[n-k];
      end
      ramp_y[n] = (s + 64) >>> 7;
      ramp_clamped[n] = (ramp_y[n] != sat_out(ramp_y[n]));
      if (n > 0 && ramp_clamped[n-1]) ramp_clamped[n] = 1'b1;
      ramp_y[n] = sat_out(ramp_y[n]);
    end
    base = out_log.size();
    for (int n = 0; n < 64; n++) send(ramp_y[n]);
    wait_log(base + 64);
    for (int n = 0; n < 64; n++) begin
      if (!ramp_clamped[n] && base + n < out_log.size()) begin
        d = longint'(out_log[base+n]) - 16 * longint'(n);
        n_cmp++;
        if (d < -1 || d > 1) begin
          n_bad++;
          $display("FAIL loopback[%0d]: got %0d expected %0d +/-1", n, out_log[base+n], 16 * n);
        end
      end
    end

    // backpressure: 10 stalled cycles in OUT with a pending input
    repeat (2) @(posedge clk);
    #1;
    flush_pulse();
    out_ready = 1'b0;
    base = out_log.size();
    send(1000);
    stall_ok = 1'b0;
    for (int i = 0; i < 40 && !stall_ok; i++) begin
      @(negedge clk);
      stall_ok = out_valid;
    end
    if (!stall_ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stall_wait: got out_valid=0 expected 1 within 40 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 18'd2000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_data", longint'($signed(out_data)), 1000);
      check("stall_valid", longint'(out_valid), 1);
      check("stall_in_ready", longint'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    stall_ok = 1'b0;
    for (int i = 0; i < 10 && !stall_ok; i++) begin
      @(negedge clk);
      stall_ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_log(base + 2);
    check_seq("backpressure", base, bp_q);

    // flush in MAC at idx 5, then flush colliding with in_valid in IDLE
    repeat (2) @(posedge clk);
    #1;
    flush_pulse();
    base = out_log.size();
    send(7777);
    repeat (4) @(posedge clk);
    #1;
    flush_pulse();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 18'd9999;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("flush_no_output", longint'(out_log.size()), longint'(base));
    send(128);
    send(0);
    send(0);
    wait_log(base + 3);
    check_seq("after_flush", base, aflush_q);

    // asynchronous reset mid-MAC, then recovery
    repeat (3) @(posedge clk);
    #1;
    send(5000);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    base = out_log.size();
    send(1);
    repeat (17) send(0);
    wait_log(base + 18);
    check_seq("recovery", base, imp1_q);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
